// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests instead of LS > IF.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [2:0]            ls_func3,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [2:0]            mem_func3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : gBadLatency
        $error("mem_port_arbiter: MEM_LATENCY must be in 1..4");
    end

    localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY - 1);
    localparam logic [2:0] FETCH_FUNC3 = 3'b010;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} arbState;

    arbState    state;
    logic [1:0] latCount;
    logic       grantLs;
    logic       storeReg;
    logic       pickLs;

`ifdef ARB_ROUND_ROBIN_EN
    logic lastGrantLs;

    // On a tie the requester that lost last time wins.
    assign pickLs = ls_req & (~if_req | ~lastGrantLs);
`else
    assign pickLs = ls_req;
`endif

    assign stall = (if_req & ~if_ready) | (ls_req & ~ls_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            latCount  <= '0;
            grantLs   <= 1'b0;
            storeReg  <= 1'b0;
            if_ready  <= 1'b0;
            ls_ready  <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_func3 <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            lastGrantLs <= 1'b0;
`endif
        end else begin
            if_ready <= 1'b0;
            ls_ready <= 1'b0;
            // The write strobe lives for the first BUSY cycle only.
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ls_req || if_req) begin
                        grantLs  <= pickLs;
                        mem_en   <= 1'b1;
                        latCount <= LAT_INIT;
                        state    <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                        lastGrantLs <= pickLs;
`endif
                        if (pickLs) begin
                            mem_addr  <= ls_addr;
                            mem_we    <= ls_we;
                            storeReg  <= ls_we;
                            mem_func3 <= ls_func3;
                            mem_wdata <= ls_wdata;
                        end else begin
                            mem_addr  <= if_addr;
                            mem_we    <= 1'b0;
                            storeReg  <= 1'b0;
                            mem_func3 <= FETCH_FUNC3;
                            mem_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (latCount == 2'd0) begin
                        mem_en <= 1'b0;
                        state  <= RESP;
                        if (grantLs) begin
                            ls_ready <= 1'b1;
                            ls_rdata <= storeReg ? '0 : mem_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        latCount <= latCount - 2'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests against a latency-aware memory model.
module tb_mem_port_arbiter;
    parameter int LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_func3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_ready;
    logic        mem_en;
    logic        mem_we;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .ls_req(ls_req), .ls_we(ls_we), .ls_func3(ls_func3), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_ready(ls_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_func3(mem_func3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: data is valid only in the LAT-th consecutive mem_en cycle.
    logic [31:0] mem [0:255];
    int enRun = 0;
    always @(posedge clk) begin
        if (mem_en) begin
            enRun <= enRun + 1;
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        end else begin
            enRun <= 0;
        end
    end
    assign mem_rdata = (mem_en && enRun == LAT - 1) ? mem[mem_addr[9:2]] : 32'hBAD0BAD0;

    typedef struct {
        logic [31:0] data;
        int          cycle;
    } expT;
    expT ifQ[$];
    expT lsQ[$];
    expT monE;

    int          weCount = 0;
    int          enCount = 0;
    logic [2:0]  lastFunc3 = '0;
    logic [31:0] lastAddr = '0;

    always @(negedge clk) begin
        if (mem_en) begin
            enCount++;
            lastFunc3 = mem_func3;
            lastAddr  = mem_addr;
            if (mem_we) weCount++;
        end
        if (if_ready || ls_ready) check("ready_exclusive", 32'(if_ready & ls_ready), 32'd0);
        if (if_ready) begin
            if (!ls_req) check("stall_at_if_ready", 32'(stall), 32'd0);
            if (ifQ.size() == 0) begin
                checks++; errors++;
                $display("FAIL if_unexpected: if_ready=1 with no fetch expected (cycle %0d)", cyc);
            end else begin
                monE = ifQ.pop_front();
                check("if_rdata", if_rdata, monE.data);
                check("if_ready_cycle", 32'(cyc), 32'(monE.cycle));
            end
        end
        if (ls_ready) begin
            if (ls_queue_nonempty()) begin
                monE = lsQ.pop_front();
                check("ls_rdata", ls_rdata, monE.data);
                check("ls_ready_cycle", 32'(cyc), 32'(monE.cycle));
            end else begin
                checks++; errors++;
                $display("FAIL ls_unexpected: ls_ready=1 with no load/store expected (cycle %0d)", cyc);
            end
        end
    end

    function automatic bit ls_queue_nonempty();
        return lsQ.size() != 0;
    endfunction

    // Waits (bounded) for the ready pulse, then returns #1 after the following edge.
    task automatic waitReady(input bit isLs);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (isLs ? ls_ready : if_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no ready pulse within 40 cycles, expected one", isLs ? "ls" : "if");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doIf(input logic [31:0] addr, input logic [31:0] data, input int rel);
        if_req  = 1'b1;
        if_addr = addr;
        ifQ.push_back('{data: data, cycle: cyc + rel});
        waitReady(1'b0);
        if_req = 1'b0;
    endtask

    task automatic doLs(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] data, input int rel);
        ls_req   = 1'b1;
        ls_we    = we;
        ls_func3 = f3;
        ls_addr  = addr;
        ls_wdata = wdata;
        lsQ.push_back('{data: data, cycle: cyc + rel});
        waitReady(1'b1);
        ls_req = 1'b0;
    endtask

    int e0;
    int w0;
    int relIf;
    int relLs;

    initial begin
        mem[4]  = 32'h00A00093;
        mem[8]  = 32'h12345678;
        mem[9]  = 32'hCAFEF00D;
        mem[16] = 32'h0BADC0DE;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_func3 = '0; ls_addr = '0; ls_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_ls_ready", 32'(ls_ready), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single fetch with stall and mem_en timing.
        e0 = enCount;
        w0 = weCount;
        if_req  = 1'b1;
        if_addr = 32'h10;
        ifQ.push_back('{data: 32'h00A00093, cycle: cyc + LAT + 1});
        @(negedge clk);
        check("fetch_stall_c0", 32'(stall), 32'd1);
        check("fetch_mem_en_c0", 32'(mem_en), 32'd0);
        @(negedge clk);
        check("fetch_mem_en_c1", 32'(mem_en), 32'd1);
        check("fetch_stall_c1", 32'(stall), 32'd1);
        waitReady(1'b0);
        if_req = 1'b0;
        check("fetch_en_cycles", 32'(enCount - e0), 32'(LAT));
        check("fetch_func3", 32'(lastFunc3), 32'd2);
        check("fetch_addr", lastAddr, 32'h10);
        check("fetch_no_write", 32'(weCount - w0), 32'd0);

        // Store then load back; store returns 0 and writes exactly once.
        w0 = weCount;
        doLs(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, LAT + 1);
        check("store_we_pulses", 32'(weCount - w0), 32'd1);
        check("store_func3", 32'(lastFunc3), 32'd2);
        doLs(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, LAT + 1);
        check("load_no_write", 32'(weCount - w0), 32'd1);
        doLs(1'b0, 3'b100, 32'h40, 32'h0, 32'h0BADC0DE, LAT + 1);
        check("load_func3_passthru", 32'(lastFunc3), 32'd4);

        // Simultaneous requests after an LS grant.
`ifdef ARB_ROUND_ROBIN_EN
        relIf = LAT + 1;
        relLs = 2 * LAT + 3;
`else
        relLs = LAT + 1;
        relIf = 2 * LAT + 3;
`endif
        fork
            doLs(1'b0, 3'b010, 32'h40, 32'h0, 32'h0BADC0DE, relLs);
            doIf(32'h20, 32'h12345678, relIf);
        join

        // Requester drops early and changes address; the latched access still completes.
        if_req  = 1'b1;
        if_addr = 32'h24;
        ifQ.push_back('{data: 32'hCAFEF00D, cycle: cyc + LAT + 1});
        @(posedge clk);
        #1;
        if_req  = 1'b0;
        if_addr = 32'h20;
        waitReady(1'b0);
        check("latched_addr", lastAddr, 32'h24);

        // Reset in the middle of a load: everything clears, no ready pulse.
        ls_req = 1'b1; ls_we = 1'b0; ls_func3 = 3'b010; ls_addr = 32'h40;
        @(posedge clk);
        #1;
        check("abort_busy_mem_en", 32'(mem_en), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_mem_en", 32'(mem_en), 32'd0);
        check("abort_ls_ready", 32'(ls_ready), 32'd0);
        check("abort_ls_rdata", ls_rdata, 32'd0);
        check("abort_if_rdata", if_rdata, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_stall_req", 32'(stall), 32'd1);
        ls_req = 1'b0;
        #1;
        check("abort_stall_idle", 32'(stall), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        doLs(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, LAT + 1);

        repeat (4) @(posedge clk);
        #1;
        check("if_queue_drained", 32'(ifQ.size()), 32'd0);
        check("ls_queue_drained", 32'(lsQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule
